// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared opcodes, FSM state encoding and default widths for
//               the sequential ALU. Optional divider: ALU_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  localparam int DEF_REG_WIDTH = 12;
  localparam int DEF_OP_WIDTH  = 4;

  localparam logic [DEF_OP_WIDTH-1:0] OP_PASS_B = 4'd0;
  localparam logic [DEF_OP_WIDTH-1:0] OP_ADD    = 4'd1;
  localparam logic [DEF_OP_WIDTH-1:0] OP_SUB    = 4'd2;
  localparam logic [DEF_OP_WIDTH-1:0] OP_INC    = 4'd3;
  localparam logic [DEF_OP_WIDTH-1:0] OP_DEC    = 4'd4;
  localparam logic [DEF_OP_WIDTH-1:0] OP_AND    = 4'd5;
  localparam logic [DEF_OP_WIDTH-1:0] OP_CLR    = 4'd6;
  localparam logic [DEF_OP_WIDTH-1:0] OP_MUL    = 4'd7;
  localparam logic [DEF_OP_WIDTH-1:0] OP_DIV    = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Request/result bundle between control unit, accumulator and
//               the sequential ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
  parameter int REG_WIDTH = 12,
  parameter int OP_WIDTH  = 4
) ();

  logic                 start;
  logic [OP_WIDTH-1:0]  op;
  logic [REG_WIDTH-1:0] a_in;
  logic [REG_WIDTH-1:0] b_in;
  logic [REG_WIDTH-1:0] result;
  logic                 ac_write_en;
  logic                 busy;
  logic                 done;

  // Requesting side (control unit / accumulator / bus)
  modport master (
    output start, op, a_in, b_in,
    input  result, ac_write_en, busy, done
  );

  // ALU side
  modport slave (
    input  start, op, a_in, b_in,
    output result, ac_write_en, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/alu_seq_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_iter
// Description : Bit-serial datapath shared by MUL (MSB-first shift-add) and,
//               when ALU_DIV_EN is defined, DIV (restoring shift-subtract).
//               Both consume the working shift register MSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int REG_WIDTH = DEF_REG_WIDTH
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 load_i,
`ifdef ALU_DIV_EN
  input  wire logic                 div_i,
`endif
  input  wire logic                 step_i,
  input  wire logic [REG_WIDTH-1:0] a_i,
  input  wire logic [REG_WIDTH-1:0] b_i,
  output logic                      last_o,
  output logic [REG_WIDTH-1:0]      res_o
);

  localparam int CNT_W = $clog2(REG_WIDTH);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(REG_WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [CNT_W-1:0]     cnt_q;
  logic [REG_WIDTH-1:0] acc_q, acc_d;   // partial product / remainder
  logic [REG_WIDTH-1:0] sh_q, sh_d;     // multiplier / dividend -> quotient
  logic [REG_WIDTH-1:0] opnd_q;         // multiplicand / divisor
`ifdef ALU_DIV_EN
  logic                 div_q;
  logic [REG_WIDTH:0]   w_rem_sh;
  logic [REG_WIDTH:0]   w_trial;
`endif

  assign last_o = (cnt_q == c_cnt_last);

  // One iteration step; res_o is the final value when last_o is high
  always_comb begin
    acc_d = {acc_q[REG_WIDTH-2:0], 1'b0} + (sh_q[REG_WIDTH-1] ? opnd_q : '0);
    sh_d  = {sh_q[REG_WIDTH-2:0], 1'b0};
    res_o = acc_d;
`ifdef ALU_DIV_EN
    w_rem_sh = {acc_q, sh_q[REG_WIDTH-1]};
    w_trial  = w_rem_sh - {1'b0, opnd_q};
    if (div_q) begin
      // Negative trial restores the shifted remainder; divide by zero never
      // goes negative, so the quotient fills with ones.
      if (!w_trial[REG_WIDTH]) begin
        acc_d = w_trial[REG_WIDTH-1:0];
        sh_d  = {sh_q[REG_WIDTH-2:0], 1'b1};
      end else begin
        acc_d = w_rem_sh[REG_WIDTH-1:0];
        sh_d  = {sh_q[REG_WIDTH-2:0], 1'b0};
      end
      res_o = sh_d;
    end
`endif
  end

  // Operand capture on accept, then one bit per clock while iterating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      sh_q   <= '0;
      opnd_q <= '0;
`ifdef ALU_DIV_EN
      div_q  <= 1'b0;
`endif
    end else if (load_i) begin
      cnt_q  <= '0;
      acc_q  <= '0;
`ifdef ALU_DIV_EN
      div_q  <= div_i;
      sh_q   <= div_i ? a_i : b_i;
      opnd_q <= div_i ? b_i : a_i;
`else
      sh_q   <= b_i;
      opnd_q <= a_i;
`endif
    end else if (step_i) begin
      cnt_q <= cnt_q + c_cnt_one;
      acc_q <= acc_d;
      sh_q  <= sh_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Multi-cycle ALU feeding the accumulator. Single-cycle ops
//               complete at the accept edge; MUL (and DIV when ALU_DIV_EN
//               is defined) run bit-serially for REG_WIDTH clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int OP_WIDTH  = DEF_OP_WIDTH
) (
  input wire logic  clk,
  input wire logic  reset,
  alu_seq_if.slave  bus
);

  state_e               state_q, state_d;
  logic [REG_WIDTH-1:0] result_q;
  logic [REG_WIDTH-1:0] w_single_res;
  logic [REG_WIDTH-1:0] w_iter_res;
  logic [OP_WIDTH-1:0]  w_op;
  logic                 w_accept, w_is_mul, w_is_div, w_iter_op;
  logic                 w_iter_last, w_iterating;

  localparam logic [REG_WIDTH-1:0] c_one = REG_WIDTH'(1);

  assign w_op        = bus.op;
  assign w_accept    = (state_q == ST_IDLE) && bus.start;
  assign w_is_mul    = (w_op == OP_MUL);
`ifdef ALU_DIV_EN
  assign w_is_div    = (w_op == OP_DIV);
`else
  assign w_is_div    = 1'b0;
`endif
  assign w_iter_op   = w_is_mul || w_is_div;
  assign w_iterating = (state_q == ST_MUL) || (state_q == ST_DIV);

  alu_seq_iter #(
    .REG_WIDTH (REG_WIDTH)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load_i (w_accept && w_iter_op),
`ifdef ALU_DIV_EN
    .div_i  (w_is_div),
`endif
    .step_i (w_iterating),
    .a_i    (bus.a_in),
    .b_i    (bus.b_in),
    .last_o (w_iter_last),
    .res_o  (w_iter_res)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: start only matters in IDLE, DONE always lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (w_is_mul)      state_d = ST_MUL;
          else if (w_is_div) state_d = ST_DIV;
          else               state_d = ST_DONE;
        end
      end
      ST_MUL, ST_DIV: if (w_iter_last) state_d = ST_DONE;
      ST_DONE:        state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  // Single-cycle results from the live operands at the accept edge;
  // unknown opcodes return A so the accumulator keeps its value
  always_comb begin
    w_single_res = bus.a_in;
    case (w_op)
      OP_PASS_B: w_single_res = bus.b_in;
      OP_ADD:    w_single_res = bus.a_in + bus.b_in;
      OP_SUB:    w_single_res = bus.a_in - bus.b_in;
      OP_INC:    w_single_res = bus.a_in + c_one;
      OP_DEC:    w_single_res = bus.a_in - c_one;
      OP_AND:    w_single_res = bus.a_in & bus.b_in;
      OP_CLR:    w_single_res = '0;
      default:   w_single_res = bus.a_in;
    endcase
  end

  // Result only updates on completion, so partial products never leak out
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           result_q <= '0;
    else if (w_accept && !w_iter_op)     result_q <= w_single_res;
    else if (w_iterating && w_iter_last) result_q <= w_iter_res;
  end

  assign bus.result      = result_q;
  assign bus.done        = (state_q == ST_DONE);
  assign bus.ac_write_en = (state_q == ST_DONE);
  assign bus.busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq (default build and
//               ALU_DIV_EN build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  alu_seq_if #(.REG_WIDTH(12), .OP_WIDTH(4)) ifc ();

  alu_seq #(.REG_WIDTH(12), .OP_WIDTH(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Present a request for exactly one rising edge; returns mid-cycle after it
  task automatic issue(input logic [3:0] o, input logic [11:0] a, input logic [11:0] b);
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = o; ifc.a_in = a; ifc.b_in = b;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  task automatic chk_single(input string tag, input logic [11:0] exp);
    chk({tag, "_res"},  {20'd0, ifc.result}, {20'd0, exp});
    chk({tag, "_done"}, {31'd0, ifc.done}, 32'd1);
    chk({tag, "_we"},   {31'd0, ifc.ac_write_en}, 32'd1);
    chk({tag, "_busy"}, {31'd0, ifc.busy}, 32'd1);
    @(negedge clk);
    chk({tag, "_done_off"}, {31'd0, ifc.done}, 32'd0);
    chk({tag, "_busy_off"}, {31'd0, ifc.busy}, 32'd0);
    chk({tag, "_hold"},     {20'd0, ifc.result}, {20'd0, exp});
  endtask

  // Observe a multi-cycle op for 20 cycles, disturbing operands and start
  task automatic run_iter(input string tag, input logic [11:0] exp, input logic [11:0] prev);
    int busy_cnt = 0, pulses = 0, we_cnt = 0, done_idx = -1, hold_err = 0;
    logic [11:0] res_done = '0;
    for (int i = 0; i < 20; i++) begin
      if (ifc.busy) busy_cnt++;
      if (ifc.ac_write_en) we_cnt++;
      if (ifc.done) begin
        pulses++;
        res_done = ifc.result;
        if (done_idx < 0) done_idx = i;
      end else if (done_idx < 0 && ifc.result !== prev) begin
        hold_err++;
      end
      if (i == 3) begin ifc.a_in = 12'($urandom); ifc.b_in = 12'($urandom); end
      if (i == 4) begin ifc.start = 1'b1; ifc.op = OP_ADD; end
      if (i == 6) ifc.start = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_pulses"},   pulses, 1);
    chk({tag, "_we_cnt"},   we_cnt, 1);
    chk({tag, "_done_at"},  done_idx, 12);
    chk({tag, "_busy_cyc"}, busy_cnt, 13);
    chk({tag, "_res"},      {20'd0, res_done}, {20'd0, exp});
    chk({tag, "_hold_end"}, {20'd0, ifc.result}, {20'd0, exp});
    chk({tag, "_no_interm"}, hold_err, 0);
  endtask

  initial begin
    int pulses;
    n_chk = 0; n_fail = 0;
    // Reset together with a pending start: reset must win
    reset = 1'b1;
    ifc.start = 1'b1; ifc.op = OP_ADD; ifc.a_in = 12'h001; ifc.b_in = 12'h001;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res",  {20'd0, ifc.result}, 32'd0);
    chk("rst_done", {31'd0, ifc.done}, 32'd0);
    chk("rst_we",   {31'd0, ifc.ac_write_en}, 32'd0);
    chk("rst_busy", {31'd0, ifc.busy}, 32'd0);
    @(negedge clk);
    ifc.start = 1'b0; reset = 1'b0;

    issue(OP_ADD, 12'h7FF, 12'h001);   chk_single("add", 12'h800);
    issue(OP_SUB, 12'h005, 12'h007);   chk_single("sub", 12'hFFE);
    issue(OP_CLR, 12'h123, 12'h456);   chk_single("clr", 12'h000);
    issue(4'hF,   12'h123, 12'h456);   chk_single("undef", 12'h123);
    issue(OP_INC, 12'hFFF, 12'h000);   chk_single("inc_wrap", 12'h000);
    issue(OP_DEC, 12'h000, 12'h000);   chk_single("dec_wrap", 12'hFFF);
    issue(OP_AND, 12'hA5A, 12'h0FF);   chk_single("and", 12'h05A);

    // Start held through the DONE cycle: second edge must be ignored
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = OP_PASS_B; ifc.a_in = 12'h111; ifc.b_in = 12'hABC;
    @(negedge clk);
    chk("pass_res",  {20'd0, ifc.result}, 32'hABC);
    chk("pass_done", {31'd0, ifc.done}, 32'd1);
    @(negedge clk);
    ifc.start = 1'b0;
    chk("done_cycle_start_ignored", {31'd0, ifc.done}, 32'd0);
    chk("done_cycle_busy", {31'd0, ifc.busy}, 32'd0);

    issue(OP_MUL, 12'h00F, 12'h011);   run_iter("mul", 12'h0FF, 12'hABC);
    issue(OP_MUL, 12'h100, 12'h010);   run_iter("mul_trunc", 12'h000, 12'h0FF);

    // Asynchronous reset between edges in the middle of a multiply
    issue(OP_MUL, 12'h003, 12'h005);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_res",  {20'd0, ifc.result}, 32'd0);
    chk("midrst_done", {31'd0, ifc.done}, 32'd0);
    chk("midrst_we",   {31'd0, ifc.ac_write_en}, 32'd0);
    chk("midrst_busy", {31'd0, ifc.busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      if (ifc.ac_write_en || ifc.busy) pulses++;
      @(negedge clk);
    end
    chk("midrst_no_pulse", pulses, 0);
    issue(OP_ADD, 12'h001, 12'h002);   chk_single("post_rst_add", 12'h003);

`ifdef ALU_DIV_EN
    issue(OP_DIV, 12'd100, 12'd7);     run_iter("div", 12'd14, 12'h003);
    issue(OP_DIV, 12'h123, 12'h000);   run_iter("div_zero", 12'hFFF, 12'd14);
`else
    issue(OP_DIV, 12'h0AB, 12'h005);   chk_single("div_undef", 12'h0AB);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
